matvec_row_sequencer: RTL and testbench

Control and buffering stage that sits directly upstream of `inner_product` in the matrix-times-vector datapath. It collects an N-element operand vector one element per cycle and holds it. It then accepts M matrix rows one packed row per handshake, drives each row and the held vector into the combinational `inner_product` instance, and returns the M results as a valid/ready output stream. The vector is reused for all M rows of one matrix; a new vector is required before the next matrix.

---
 rtl/matvec_row_sequencer.sv | 101 ++++++++++
 tb/tb_matvec_row_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matvec_row_sequencer.sv
// Operand sequencer for inner_product: loads and holds an N-element vector,
// then streams M rows through the dot-product unit and returns one result per row.
module matvec_row_sequencer #(
  parameter int unsigned N  = 4,
  parameter int unsigned DW = 8,
  parameter int unsigned M  = 4,
  parameter int unsigned OW = 2*DW + $bits(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DW-1:0]   vec_in,
  input  logic            vec_valid,
  output logic            vec_ready,
  input  logic [DW*N-1:0] row_in,
  input  logic            row_valid,
  output logic            row_ready,
  output logic [DW*N-1:0] ip_a,
  output logic [DW*N-1:0] ip_b,
  input  logic [OW-1:0]   ip_result,
  output logic [OW-1:0]   y_out,
  output logic            y_valid,
  input  logic            y_ready,
  output logic            y_last,
  output logic            busy
);

  localparam int unsigned EW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned RW = (M > 1) ? $clog2(M) : 1;
  localparam logic [EW-1:0] ELEM_LAST = EW'(N - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(M - 1);

  typedef enum logic [1:0] {
    LOAD_VEC,
    ROWS,
    CALC,
    OUT
  } state_t;

  state_t        state, state_n;
  logic [EW-1:0] elem_cnt;
  logic [RW-1:0] row_cnt;
  logic          vec_hs, row_hs, y_hs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD_VEC;
    else     state <= state_n;
  end

  // Handshake strobes decode from registered state only; no input-to-ready path.
  always_comb begin
    state_n   = state;
    vec_ready = 1'b0;
    row_ready = 1'b0;
    y_valid   = 1'b0;
    busy      = !((state == LOAD_VEC) && (elem_cnt == '0));
    case (state)
      LOAD_VEC: begin
        vec_ready = 1'b1;
        if (vec_valid && (elem_cnt == ELEM_LAST)) state_n = ROWS;
      end
      ROWS: begin
        row_ready = 1'b1;
        if (row_valid) state_n = CALC;
      end
      CALC: state_n = OUT;
      OUT: begin
        y_valid = 1'b1;
        if (y_ready) state_n = (row_cnt == ROW_LAST) ? LOAD_VEC : ROWS;
      end
      default: state_n = LOAD_VEC;
    endcase
  end

  assign vec_hs = vec_ready & vec_valid;
  assign row_hs = row_ready & row_valid;
  assign y_hs   = y_valid & y_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      elem_cnt <= '0;
      row_cnt  <= '0;
      ip_a     <= '0;
      ip_b     <= '0;
      y_out    <= '0;
      y_last   <= 1'b0;
    end else begin
      if (vec_hs) begin
        ip_b[int'(elem_cnt)*DW +: DW] <= vec_in;
        elem_cnt <= (elem_cnt == ELEM_LAST) ? '0 : elem_cnt + 1'b1;
      end
      if (row_hs) ip_a <= row_in;
      // ip_result settles during CALC from the row registered on the previous edge.
      if (state == CALC) begin
        y_out  <= ip_result;
        y_last <= (row_cnt == ROW_LAST);
      end
      if (y_hs) row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_matvec_row_sequencer.sv
// Scoreboard bench for matvec_row_sequencer: expected dot products are queued at
// row issue and popped by an independent monitor on each y handshake.
module tb_matvec_row_sequencer;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned M  = 2;
  localparam int unsigned OW = 48;

  typedef logic [N-1:0][DW-1:0] row_t;
  typedef struct packed {
    logic [OW-1:0] y;
    logic          last;
  } exp_t;

  logic            clk, rst;
  logic [DW-1:0]   vec_in;
  logic            vec_valid, vec_ready;
  logic [DW*N-1:0] row_in;
  logic            row_valid, row_ready;
  logic [DW*N-1:0] ip_a, ip_b;
  logic [OW-1:0]   ip_result, y_out;
  logic            y_valid, y_ready, y_last, busy;

  matvec_row_sequencer #(.N(N), .DW(DW), .M(M), .OW(OW)) dut (
    .clk(clk), .rst(rst),
    .vec_in(vec_in), .vec_valid(vec_valid), .vec_ready(vec_ready),
    .row_in(row_in), .row_valid(row_valid), .row_ready(row_ready),
    .ip_a(ip_a), .ip_b(ip_b), .ip_result(ip_result),
    .y_out(y_out), .y_valid(y_valid), .y_ready(y_ready), .y_last(y_last),
    .busy(busy)
  );

  // Stand-in for the downstream combinational inner_product unit.
  function automatic logic [OW-1:0] inner_product(logic [DW*N-1:0] a, logic [DW*N-1:0] b);
    longint unsigned s = 0;
    for (int k = 0; k < N; k++) s += longint'(a[k*DW +: DW]) * longint'(b[k*DW +: DW]);
    return OW'(s);
  endfunction
  always_comb ip_result = inner_product(ip_a, ip_b);

  // Reference: a result is the plain sum of products of the held vector and the row.
  function automatic longint unsigned ref_dot(row_t v, row_t r);
    longint unsigned s = 0;
    for (int k = 0; k < N; k++) s += longint'(v[k]) * longint'(r[k]);
    return s;
  endfunction

  int   checks = 0, passes = 0;
  exp_t q[$];
  row_t cur_vec;
  int   rowidx = 0;
  bit   bp_hold = 0, rand_bp = 0;

  task automatic check(input string name, input longint unsigned got, input longint unsigned exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passes, checks);
    $fatal(1);
  end

  initial begin
    y_ready = 1'b1;
    forever begin
      @(negedge clk);
      y_ready = bp_hold ? 1'b0 : (rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  // Monitor: evaluates each cycle shortly after the falling edge, once inputs are settled.
  initial begin
    bit            stall = 0;
    logic [OW-1:0] hy;
    logic          hl;
    exp_t          e;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        stall = 0;
        continue;
      end
      check("ready_exclusive", vec_ready & row_ready, 0);
      if (stall) begin
        check("y_valid_hold", y_valid, 1);
        check("y_out_hold", y_out, hy);
        check("y_last_hold", y_last, hl);
      end
      stall = 0;
      if (y_valid) begin
        if (y_ready) begin
          check("scoreboard_nonempty", q.size() != 0, 1);
          if (q.size() != 0) begin
            e = q.pop_front();
            check("y_out", y_out, e.y);
            check("y_last", y_last, e.last);
          end
        end else begin
          stall = 1;
          hy = y_out;
          hl = y_last;
        end
      end
    end
  end

  task automatic send_vec(input row_t v, input bit gapped, input bit offer, input row_t early);
    int t;
    if (offer) begin
      row_valid = 1'b1;
      row_in    = early;
    end
    for (int k = 0; k < N; k++) begin
      if (gapped && k > 0) @(negedge clk);
      t = 0;
      forever begin
        @(negedge clk);
        vec_valid = 1'b1;
        vec_in    = v[k];
        if (offer) check("early_row_blocked", row_ready, 0);
        if (vec_ready) break;
        if (++t > 50) begin
          check("vec_timeout", 0, 1);
          vec_valid = 1'b0;
          return;
        end
      end
      @(posedge clk);
      #1;
      vec_valid = 1'b0;
      vec_in    = DW'($urandom);
    end
    cur_vec = v;
    @(negedge clk);
    row_valid = 1'b0;
    check("ip_b_lanes", ip_b, v);
    check("row_ready_after_vec", row_ready, 1);
    check("vec_ready_after_vec", vec_ready, 0);
  endtask

  task automatic send_row(input row_t r);
    int t = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      row_valid = 1'b1;
      row_in    = r;
      if (row_ready) break;
      if (++t > 50) begin
        check("row_timeout", 0, 1);
        row_valid = 1'b0;
        return;
      end
    end
    e.y    = OW'(ref_dot(cur_vec, r));
    e.last = (rowidx == M - 1);
    q.push_back(e);
    rowidx = (rowidx + 1) % M;
    @(posedge clk);
    #1;
    row_valid = 1'b0;
    row_in    = (DW*N)'($urandom);
    check("ip_a_row", ip_a, r);
  endtask

  task automatic wait_y_valid();
    int t = 0;
    while (!y_valid) begin
      @(negedge clk);
      #3;
      if (++t > 50) begin
        check("y_valid_timeout", 0, 1);
        return;
      end
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (q.size() != 0) begin
      @(negedge clk);
      #3;
      if (++t > 200) begin
        check("drain_timeout", q.size(), 0);
        return;
      end
    end
    @(negedge clk);
    #3;
    check("idle_vec_ready", vec_ready, 1);
    check("idle_busy", busy, 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_vec_ready", vec_ready, 1);
    check("rst_row_ready", row_ready, 0);
    check("rst_y_valid", y_valid, 0);
    check("rst_y_last", y_last, 0);
    check("rst_busy", busy, 0);
    check("rst_y_out", y_out, 0);
    check("rst_ip_a", ip_a, 0);
    check("rst_ip_b", ip_b, 0);
  endtask

  initial begin
    row_t v, r0, r1, none;
    none      = '0;
    rst       = 1'b1;
    vec_valid = 1'b0;
    vec_in    = '0;
    row_valid = 1'b0;
    row_in    = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b0;

    // Basic matrix with a row offered early during vector load.
    v  = {8'd4, 8'd3, 8'd2, 8'd1};
    r0 = {8'd1, 8'd1, 8'd1, 8'd1};
    r1 = {8'd1, 8'd2, 8'd3, 8'd4};
    send_vec(v, 1'b0, 1'b1, r0);
    send_row(r0);
    send_row(r1);
    wait_idle();

    // Gapped vector load, then backpressure with a row held on the input.
    v = {8'd8, 8'd7, 8'd6, 8'd5};
    send_vec(v, 1'b1, 1'b0, none);
    bp_hold = 1;
    send_row(r0);
    wait_y_valid();
    repeat (5) begin
      @(negedge clk);
      row_valid = 1'b1;
      row_in    = r1;
      #3;
      check("bp_y_valid", y_valid, 1);
      check("bp_row_ready", row_ready, 0);
    end
    bp_hold = 0;
    send_row(r1);
    wait_idle();

    // All-ones data: 4*255*255 must appear untruncated.
    v = '1;
    send_vec(v, 1'b0, 1'b0, none);
    send_row(v);
    send_row(v);
    wait_idle();

    // Reset while a result is pending in OUT.
    v = {N{DW'($urandom)}};
    send_vec(v, 1'b0, 1'b0, none);
    bp_hold = 1;
    send_row(r1);
    wait_y_valid();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs();
    q.delete();
    rowidx  = 0;
    bp_hold = 0;
    @(negedge clk);
    rst = 1'b0;
    v = {8'd2, 8'd2, 8'd2, 8'd2};
    send_vec(v, 1'b0, 1'b0, none);
    send_row(r0);
    send_row(r1);
    wait_idle();

    // Randomized back-to-back matrices with random gaps and backpressure.
    rand_bp = 1;
    for (int m = 0; m < 15; m++) begin
      for (int k = 0; k < N; k++) v[k] = DW'($urandom);
      send_vec(v, bit'($urandom_range(0, 1)), 1'b0, none);
      for (int r = 0; r < M; r++) begin
        for (int k = 0; k < N; k++) r0[k] = DW'($urandom);
        send_row(r0);
      end
      wait_idle();
    end
    rand_bp = 0;

    check("pending_results", q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
